// File: rtl/pll_reconfig_seq.sv
// Programs the RAM-clock PLL through the reconfiguration controller's Avalon-MM port:
// eight fixed register writes, a timed PLL reset pulse, then a bounded wait for lock.
module pll_reconfig_seq #(
   parameter int          GAP_CYCLES   = 8,
   parameter int          RESET_CYCLES = 8,
   parameter int          LOCK_TIMEOUT = 5000000,
   parameter logic [31:0] N_VAL        = 32'h10000,
   parameter logic [31:0] CP_VAL       = 32'd1,
   parameter logic [31:0] BW_VAL       = 32'd7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] m_val,
   input  logic [31:0] k_val,
   input  logic [31:0] c0_val,
   input  logic        locked,
   input  logic        mgmt_waitrequest,
   output logic        mgmt_write,
   output logic [5:0]  mgmt_address,
   output logic [31:0] mgmt_writedata,
   output logic        pll_reset,
   output logic        busy,
   output logic        done,
   output logic        lock_err
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_WRITE     = 3'd1;
   localparam logic [2:0] ST_GAP       = 3'd2;
   localparam logic [2:0] ST_PLLRST    = 3'd3;
   localparam logic [2:0] ST_WAIT_LOCK = 3'd4;

   localparam logic [7:0]  GAP_LOAD  = 8'(GAP_CYCLES - 1);
   localparam logic [7:0]  RST_LOAD  = 8'(RESET_CYCLES - 1);
   localparam logic [31:0] LOCK_LAST = 32'(LOCK_TIMEOUT - 1);

   // Register addresses in write order; step 0 sits in the least significant field.
   localparam logic [47:0] ADDR_LIST = {6'd2, 6'd8, 6'd9, 6'd5, 6'd3, 6'd7, 6'd4, 6'd0};

   logic [2:0]  state_reg;
   logic [2:0]  step_reg;
   logic [7:0]  cnt_reg;
   logic [31:0] lock_cnt_reg;
   logic        pending_reg;
   logic [31:0] m_reg;
   logic [31:0] k_reg;
   logic [31:0] c0_reg;
   logic        write_reg;
   logic [5:0]  addr_reg;
   logic [31:0] data_reg;
   logic        pll_reset_reg;
   logic        busy_reg;
   logic        done_reg;
   logic        lock_err_reg;

   logic [5:0]  tbl_addr [8];
   logic [31:0] tbl_data [8];
   logic [2:0]  step_next;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_addr
         assign tbl_addr[gi] = ADDR_LIST[gi*6 +: 6];
      end
   endgenerate

   always_comb begin
      tbl_data[0] = 32'd0;
      tbl_data[1] = m_reg;
      tbl_data[2] = k_reg;
      tbl_data[3] = N_VAL;
      tbl_data[4] = c0_reg;
      tbl_data[5] = CP_VAL;
      tbl_data[6] = BW_VAL;
      tbl_data[7] = 32'd0;
   end

   assign step_next = step_reg + 3'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         step_reg      <= '0;
         cnt_reg       <= '0;
         lock_cnt_reg  <= '0;
         pending_reg   <= 1'b0;
         m_reg         <= '0;
         k_reg         <= '0;
         c0_reg        <= '0;
         write_reg     <= 1'b0;
         addr_reg      <= '0;
         data_reg      <= '0;
         pll_reset_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         lock_err_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (start && state_reg != ST_IDLE)
            pending_reg <= 1'b1;

         case (state_reg)
            ST_IDLE: begin
               // A queued request relaunches in the done cycle itself.
               if (start || pending_reg) begin
                  m_reg        <= m_val;
                  k_reg        <= k_val;
                  c0_reg       <= c0_val;
                  lock_err_reg <= 1'b0;
                  pending_reg  <= 1'b0;
                  step_reg     <= '0;
                  write_reg    <= 1'b1;
                  addr_reg     <= tbl_addr[0];
                  data_reg     <= 32'd0;
                  busy_reg     <= 1'b1;
                  state_reg    <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (!mgmt_waitrequest) begin
                  write_reg <= 1'b0;
                  cnt_reg   <= GAP_LOAD;
                  state_reg <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (cnt_reg == 8'd0) begin
                  if (step_reg != 3'd7) begin
                     step_reg  <= step_next;
                     write_reg <= 1'b1;
                     addr_reg  <= tbl_addr[step_next];
                     data_reg  <= tbl_data[step_next];
                     state_reg <= ST_WRITE;
                  end else begin
                     pll_reset_reg <= 1'b1;
                     cnt_reg       <= RST_LOAD;
                     state_reg     <= ST_PLLRST;
                  end
               end else begin
                  cnt_reg <= cnt_reg - 8'd1;
               end
            end
            ST_PLLRST: begin
               if (cnt_reg == 8'd0) begin
                  pll_reset_reg <= 1'b0;
                  lock_cnt_reg  <= '0;
                  state_reg     <= ST_WAIT_LOCK;
               end else begin
                  cnt_reg <= cnt_reg - 8'd1;
               end
            end
            ST_WAIT_LOCK: begin
               // locked may still be stale right after the reset edge, so skip count 0.
               if (lock_cnt_reg != 32'd0 && locked) begin
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
               end else if (lock_cnt_reg == LOCK_LAST) begin
                  done_reg     <= 1'b1;
                  busy_reg     <= 1'b0;
                  lock_err_reg <= 1'b1;
                  state_reg    <= ST_IDLE;
               end else begin
                  lock_cnt_reg <= lock_cnt_reg + 32'd1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign mgmt_write     = write_reg;
   assign mgmt_address   = addr_reg;
   assign mgmt_writedata = data_reg;
   assign pll_reset      = pll_reset_reg;
   assign busy           = busy_reg;
   assign done           = done_reg;
   assign lock_err       = lock_err_reg;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Scoreboard bench for pll_reconfig_seq: expected writes and done events are queued
// when a start is driven and compared as the sequencer produces them.
module tb_pll_reconfig_seq;

   localparam int GAP   = 8;
   localparam int RST   = 8;
   localparam int LOCKT = 100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] m_val = '0;
   logic [31:0] k_val = '0;
   logic [31:0] c0_val = '0;
   logic        locked = 1'b0;
   logic        mgmt_waitrequest = 1'b0;
   logic        mgmt_write;
   logic [5:0]  mgmt_address;
   logic [31:0] mgmt_writedata;
   logic        pll_reset;
   logic        busy;
   logic        done;
   logic        lock_err;

   pll_reconfig_seq #(
      .GAP_CYCLES   (GAP),
      .RESET_CYCLES (RST),
      .LOCK_TIMEOUT (LOCKT),
      .N_VAL        (32'h10000),
      .CP_VAL       (32'd1),
      .BW_VAL       (32'd7)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .m_val            (m_val),
      .k_val            (k_val),
      .c0_val           (c0_val),
      .locked           (locked),
      .mgmt_waitrequest (mgmt_waitrequest),
      .mgmt_write       (mgmt_write),
      .mgmt_address     (mgmt_address),
      .mgmt_writedata   (mgmt_writedata),
      .pll_reset        (pll_reset),
      .busy             (busy),
      .done             (done),
      .lock_err         (lock_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  addr;
      logic [31:0] data;
      int          gap;
      int          hold;
   } wr_t;

   typedef struct {
      logic err;
      int   delay;
   } done_t;

   wr_t   exp_wr[$];
   done_t exp_done[$];

   int checks = 0;
   int failures = 0;
   int lock_delay = 3;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic push_run(input logic [31:0] m, input logic [31:0] k, input logic [31:0] c0,
                           input bit stall_k);
      logic [5:0]  a [8];
      logic [31:0] d [8];
      wr_t e;
      a = '{6'd0, 6'd4, 6'd7, 6'd3, 6'd5, 6'd9, 6'd8, 6'd2};
      d = '{32'd0, m, k, 32'h10000, c0, 32'd1, 32'd7, 32'd0};
      for (int i = 0; i < 8; i++) begin
         e.addr = a[i];
         e.data = d[i];
         e.gap  = (i == 0) ? 1 : GAP + 1;
         e.hold = 1;
         if (stall_k && i == 2) begin
            e.gap  = GAP + 1 + 3;
            e.hold = 4;
         end
         exp_wr.push_back(e);
      end
   endtask

   task automatic push_done(input logic err, input int delay);
      done_t e;
      e.err   = err;
      e.delay = delay;
      exp_done.push_back(e);
   endtask

   task automatic do_start(input logic [31:0] m, input logic [31:0] k, input logic [31:0] c0);
      @(posedge clk);
      #1;
      m_val  = m;
      k_val  = k;
      c0_val = c0;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      $display("start m=%0h k=%0h c0=%0h", m, k, c0);
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while ((exp_wr.size() != 0 || exp_done.size() != 0) && n < budget) begin
         @(posedge clk);
         n++;
      end
      check({tag, "_timeout"}, 64'(n >= budget), 64'd0);
      repeat (2) @(posedge clk);
   endtask

   task automatic wait_write(input logic [5:0] addr, input int budget);
      int n = 0;
      bit found = 0;
      while (!found && n < budget) begin
         @(posedge clk);
         #1;
         n++;
         if (mgmt_write && mgmt_address == addr)
            found = 1;
      end
      check("wait_write_timeout", 64'(found), 64'd1);
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({mgmt_write, mgmt_address, mgmt_writedata, pll_reset, busy, done, lock_err});
   endfunction

   // PLL model: lock asserts lock_delay cycles after pll_reset falls (never if negative).
   initial begin
      int  since = -1;
      bit  pr_prev = 0;
      forever begin
         @(posedge clk);
         #2;
         if (reset || pll_reset) begin
            since  = -1;
            locked = 1'b0;
         end else begin
            if (pr_prev) since = 0;
            else if (since >= 0) since++;
            locked = (lock_delay >= 0 && since >= lock_delay);
         end
         pr_prev = pll_reset && !reset;
      end
   end

   // Output monitor, sampled on the falling edge.
   initial begin
      int  cyc = 0;
      int  ref_cyc = 0;
      int  fall_cyc = 0;
      int  hold = 0;
      int  pr_hi = 0;
      bit  pr_prev = 0;
      wr_t   w;
      done_t de;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            pr_prev = 0;
            pr_hi   = 0;
            hold    = 0;
            ref_cyc = cyc;
         end else begin
            if (mgmt_write) begin
               hold++;
               if (mgmt_waitrequest && exp_wr.size() != 0) begin
                  check("stall_addr", 64'(mgmt_address), 64'(exp_wr[0].addr));
                  check("stall_data", 64'(mgmt_writedata), 64'(exp_wr[0].data));
               end
               if (!mgmt_waitrequest) begin
                  if (exp_wr.size() == 0) begin
                     check("unexpected_write", 64'(mgmt_address), 64'h3f);
                  end else begin
                     w = exp_wr.pop_front();
                     $display("write addr=%0d data=%0h cycle=%0d hold=%0d", mgmt_address,
                              mgmt_writedata, cyc, hold);
                     check("wr_addr", 64'(mgmt_address), 64'(w.addr));
                     check("wr_data", 64'(mgmt_writedata), 64'(w.data));
                     check("wr_spacing", 64'(cyc - ref_cyc), 64'(w.gap));
                     check("wr_hold", 64'(hold), 64'(w.hold));
                  end
                  ref_cyc = cyc;
                  hold    = 0;
               end
            end
            if (pll_reset) pr_hi++;
            if (pr_prev && !pll_reset) begin
               check("pll_reset_len", 64'(pr_hi), 64'(RST));
               fall_cyc = cyc;
               pr_hi    = 0;
            end
            pr_prev = pll_reset;
            if (done) begin
               check("done_busy", 64'(busy), 64'd0);
               if (exp_done.size() == 0) begin
                  check("unexpected_done", 64'(done), 64'd0);
               end else begin
                  de = exp_done.pop_front();
                  $display("done lock_err=%0b delay=%0d", lock_err, cyc - fall_cyc);
                  check("done_lock_err", 64'(lock_err), 64'(de.err));
                  check("done_delay", 64'(cyc - fall_cyc), 64'(de.delay));
               end
               ref_cyc = cyc;
            end else if (start && !busy) begin
               ref_cyc = cyc;
            end
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #1 check("reset_outputs", all_outs(), 64'd0);

      // Nominal run
      lock_delay = 3;
      push_run(32'd167, 32'd808, 32'hB33332DD, 0);
      push_done(1'b0, 4);
      do_start(32'd167, 32'd808, 32'hB33332DD);
      wait_drain("nominal", 400);
      check("nominal_lock_err", 64'(lock_err), 64'd0);

      // Waitrequest stall on the K write
      push_run(32'd167, 32'd808, 32'hB33332DD, 1);
      push_done(1'b0, 4);
      do_start(32'd167, 32'd808, 32'hB33332DD);
      wait_write(6'd7, 200);
      mgmt_waitrequest = 1'b1;
      repeat (3) @(posedge clk);
      #1 mgmt_waitrequest = 1'b0;
      wait_drain("stall", 400);

      // Lock timeout, then a fresh start clears lock_err
      lock_delay = -1;
      push_run(32'h11, 32'h22, 32'h33, 0);
      push_done(1'b1, LOCKT);
      do_start(32'h11, 32'h22, 32'h33);
      wait_drain("timeout", 500);
      repeat (5) @(posedge clk);
      check("lock_err_sticky", 64'(lock_err), 64'd1);
      lock_delay = 3;
      push_run(32'h44, 32'h55, 32'h66, 0);
      push_done(1'b0, 4);
      do_start(32'h44, 32'h55, 32'h66);
      check("lock_err_cleared", 64'(lock_err), 64'd0);
      check("busy_after_start", 64'(busy), 64'd1);
      wait_drain("after_timeout", 400);

      // Starts while busy collapse into one rerun with the latest inputs
      push_run(32'hA0, 32'hA1, 32'hA2, 0);
      push_done(1'b0, 4);
      do_start(32'hA0, 32'hA1, 32'hA2);
      wait_write(6'd7, 200);
      do_start(32'hB0, 32'hA1, 32'hA2);
      wait_write(6'd9, 200);
      push_run(32'hC0, 32'hA1, 32'hA2, 0);
      push_done(1'b0, 4);
      do_start(32'hC0, 32'hA1, 32'hA2);
      wait_drain("pending", 600);
      repeat (100) @(posedge clk);
      check("no_second_rerun_busy", 64'(busy), 64'd0);

      // Inputs changing right after start do not affect the run
      push_run(32'h1234, 32'h5678, 32'h9ABC, 0);
      push_done(1'b0, 4);
      do_start(32'h1234, 32'h5678, 32'h9ABC);
      m_val = 32'hDEAD;
      k_val = 32'hBEEF;
      wait_drain("input_change", 400);

      // Reset while pll_reset is high
      push_run(32'h7, 32'h8, 32'h9, 0);
      do_start(32'h7, 32'h8, 32'h9);
      begin
         int n = 0;
         while (!pll_reset && n < 200) begin
            @(posedge clk);
            #1;
            n++;
         end
         check("wait_pll_reset_timeout", 64'(n >= 200), 64'd0);
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      exp_wr.delete();
      exp_done.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      #1 check("reset_in_pllrst", all_outs(), 64'd0);

      // Reset mid-write (write stalled), then a clean run from address 0
      push_run(32'h31, 32'h32, 32'h33, 0);
      do_start(32'h31, 32'h32, 32'h33);
      wait_write(6'd4, 200);
      mgmt_waitrequest = 1'b1;
      reset = 1'b1;
      exp_wr.delete();
      exp_done.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      mgmt_waitrequest = 1'b0;
      #1 check("reset_mid_write", all_outs(), 64'd0);
      push_run(32'h41, 32'h42, 32'h43, 0);
      push_done(1'b0, 4);
      do_start(32'h41, 32'h42, 32'h43);
      wait_drain("after_reset", 400);

      check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
      check("done_queue_empty", 64'(exp_done.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
